// File: rtl/instr_fetch_reg_if.sv
// Bundle between the fetch/IR stage, the control unit, instruction memory and the
// immediate extender. The fetch stage is the slave; its environment is the master.
interface instr_fetch_reg_if;
  logic        fetch_req;
  logic        flush;
  logic [63:0] pc;
  logic [63:0] imem_addr;
  logic        imem_rd;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [3:0]  imm_sel;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        instr_valid;
  logic        illegal;
  logic        busy;
  logic        fetch_err;

  modport slave (
    input  fetch_req, flush, pc, imem_ready, imem_data,
    output imem_addr, imem_rd, instr, imm_sel, opcode, rd, rs1, rs2,
           funct3, funct7, instr_valid, illegal, busy, fetch_err
  );

  modport master (
    output fetch_req, flush, pc, imem_ready, imem_data,
    input  imem_addr, imem_rd, instr, imm_sel, opcode, rd, rs1, rs2,
           funct3, funct7, instr_valid, illegal, busy, fetch_err
  );
endinterface

// File: rtl/instr_fetch_reg.sv
// Instruction fetch + instruction register: issues a read, waits (bounded) for memory,
// latches the word and decodes the immediate type for the downstream extender.
module instr_fetch_reg #(
  parameter int TIMEOUT = 15
) (
  input logic              clk,
  input logic              reset_n,
  instr_fetch_reg_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [7:0]  r_cnt;
  logic [63:0] r_addr;
  logic [31:0] r_instr;
  logic [3:0]  r_immSel;
  logic        r_illegal;
  logic        r_valid;
  logic        r_fetchErr;

  logic        w_reqOk;
  logic        w_accept;
  logic        w_misalign;
  logic        w_capture;
  logic        w_stall;
  logic        w_timeout;
  logic        w_rd;
  logic        w_busy;
  logic [3:0]  w_decSel;
  logic        w_decIllegal;

  assign w_reqOk    = (r_state == IDLE) && bus.fetch_req && !bus.flush;
  assign w_accept   = w_reqOk && (bus.pc[1:0] == 2'b00);
  assign w_misalign = w_reqOk && (bus.pc[1:0] != 2'b00);
  assign w_capture  = (r_state == WAIT) && bus.imem_ready && !bus.flush;
  assign w_stall    = (r_state == WAIT) && !bus.imem_ready && !bus.flush;
  assign w_timeout  = w_stall && (r_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = WAIT;
      WAIT:    if (bus.flush || bus.imem_ready || w_timeout) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_rd   = (r_state == WAIT);
    w_busy = (r_state != IDLE);
  end

  // Value 5 is left free for the load-byte path and is never produced here.
  always_comb begin
    w_decSel     = 4'd0;
    w_decIllegal = 1'b0;
    case (bus.imem_data[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: w_decSel = 4'd0;
      7'b0100011:             w_decSel = 4'd1;
      7'b1100011:             w_decSel = 4'd2;
      7'b0110111, 7'b0010111: w_decSel = 4'd3;
      7'b1101111:             w_decSel = 4'd4;
      7'b0110011:             w_decSel = 4'd0;
      default:                w_decIllegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_instr    <= '0;
      r_immSel   <= '0;
      r_illegal  <= 1'b0;
      r_valid    <= 1'b0;
      r_fetchErr <= 1'b0;
    end else begin
      r_valid <= w_capture;
      if (w_accept) begin
        r_addr     <= bus.pc;
        r_fetchErr <= 1'b0;
        r_cnt      <= '0;
      end
      if (w_misalign) r_fetchErr <= 1'b1;
      if (w_capture) begin
        r_instr   <= bus.imem_data;
        r_immSel  <= w_decSel;
        r_illegal <= w_decIllegal;
      end
      if (w_timeout)    r_fetchErr <= 1'b1;
      else if (w_stall) r_cnt      <= r_cnt + 8'd1;
    end
  end

  assign bus.imem_addr   = r_addr;
  assign bus.imem_rd     = w_rd;
  assign bus.busy        = w_busy;
  assign bus.instr       = r_instr;
  assign bus.imm_sel     = r_immSel;
  assign bus.illegal     = r_illegal;
  assign bus.instr_valid = r_valid;
  assign bus.fetch_err   = r_fetchErr;
  assign bus.opcode      = r_instr[6:0];
  assign bus.rd          = r_instr[11:7];
  assign bus.funct3      = r_instr[14:12];
  assign bus.rs1         = r_instr[19:15];
  assign bus.rs2         = r_instr[24:20];
  assign bus.funct7      = r_instr[31:25];

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Directed bench for instr_fetch_reg: expected instructions are queued when a fetch is
// issued and popped when the stage reports instr_valid.
module tb_instr_fetch_reg;

  logic clk;
  logic reset_n;
  int   nTests = 0;
  int   nFail  = 0;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  immSel;
    logic        illegal;
  } exp_t;

  exp_t expQ[$];

  instr_fetch_reg_if bus ();

  instr_fetch_reg #(.TIMEOUT(15)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one fetch with nWait idle memory cycles before imem_ready, then scores the result.
  task automatic applyStimulus(input logic [63:0] pcIn, input logic [31:0] data,
                               input int nWait, input logic [3:0] sel, input logic ill);
    int   rdCycles;
    int   cyc;
    bit   got;
    exp_t e;
    rdCycles = 0;
    cyc      = 0;
    got      = 1'b0;
    expQ.push_back('{instr: data, immSel: sel, illegal: ill});
    bus.pc        = pcIn;
    bus.fetch_req = 1'b1;
    @(negedge clk);
    bus.fetch_req = 1'b0;
    while (!got && cyc < 40) begin
      if (bus.instr_valid) begin
        got = 1'b1;
      end else begin
        if (bus.imem_rd) begin
          rdCycles++;
          checkOutput("waitAddr", bus.imem_addr, pcIn);
          checkOutput("waitBusy", 64'(bus.busy), 64'd1);
        end
        bus.imem_ready = bus.imem_rd && (rdCycles == nWait + 1);
        bus.imem_data  = bus.imem_ready ? data : 32'hDEAD_BEEF;
        @(negedge clk);
        cyc++;
      end
    end
    bus.imem_ready = 1'b0;
    checkOutput("validSeen", 64'(got), 64'd1);
    checkOutput("rdCycles", 64'(rdCycles), 64'(nWait + 1));
    checkOutput("latency", 64'(cyc), 64'(nWait + 1));
    checkOutput("rdDropped", 64'(bus.imem_rd), 64'd0);
    if (got && expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("instr", 64'(bus.instr), 64'(e.instr));
      checkOutput("immSel", 64'(bus.imm_sel), 64'(e.immSel));
      checkOutput("illegal", 64'(bus.illegal), 64'(e.illegal));
      checkOutput("opcode", 64'(bus.opcode), 64'(e.instr[6:0]));
    end
    @(negedge clk);
    checkOutput("validPulse", 64'(bus.instr_valid), 64'd0);
  endtask

  initial begin
    int rdCycles;
    reset_n        = 1'b0;
    bus.fetch_req  = 1'b0;
    bus.flush      = 1'b0;
    bus.pc         = '0;
    bus.imem_ready = 1'b0;
    bus.imem_data  = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    checkOutput("rstInstr", 64'(bus.instr), 64'd0);
    checkOutput("rstImmSel", 64'(bus.imm_sel), 64'd0);
    checkOutput("rstAddr", bus.imem_addr, 64'd0);
    checkOutput("rstRd", 64'(bus.imem_rd), 64'd0);
    checkOutput("rstBusy", 64'(bus.busy), 64'd0);
    checkOutput("rstErr", 64'(bus.fetch_err), 64'd0);
    checkOutput("rstValid", 64'(bus.instr_valid), 64'd0);
    checkOutput("rstIllegal", 64'(bus.illegal), 64'd0);

    applyStimulus(64'h40, 32'h00A0_0093, 0, 4'd0, 1'b0);
    checkOutput("fieldRd", 64'(bus.rd), 64'd1);
    checkOutput("fieldRs1", 64'(bus.rs1), 64'd0);
    checkOutput("fieldRs2", 64'(bus.rs2), 64'd10);
    checkOutput("fieldFunct3", 64'(bus.funct3), 64'd0);
    checkOutput("fieldFunct7", 64'(bus.funct7), 64'd0);

    applyStimulus(64'h44, 32'hFE11_2E23, 3, 4'd1, 1'b0);
    applyStimulus(64'h80, 32'h0000_006F, 1, 4'd4, 1'b0);
    applyStimulus(64'h84, 32'h0000_12B7, 0, 4'd3, 1'b0);
    applyStimulus(64'h88, 32'hFE00_08E3, 2, 4'd2, 1'b0);
    checkOutput("holdInstr", 64'(bus.instr), 64'hFE00_08E3);

    // Memory never answers: the read strobe must give up after TIMEOUT cycles.
    rdCycles      = 0;
    bus.pc        = 64'h90;
    bus.fetch_req = 1'b1;
    @(negedge clk);
    bus.fetch_req = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.imem_rd) rdCycles++;
      checkOutput("toNoValid", 64'(bus.instr_valid), 64'd0);
      @(negedge clk);
    end
    checkOutput("toRdCycles", 64'(rdCycles), 64'd15);
    checkOutput("toErr", 64'(bus.fetch_err), 64'd1);
    checkOutput("toBusy", 64'(bus.busy), 64'd0);
    checkOutput("toInstrKept", 64'(bus.instr), 64'hFE00_08E3);

    applyStimulus(64'h94, 32'h0000_0013, 0, 4'd0, 1'b0);
    checkOutput("errCleared", 64'(bus.fetch_err), 64'd0);

    bus.pc        = 64'h42;
    bus.fetch_req = 1'b1;
    @(negedge clk);
    bus.fetch_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("misRd", 64'(bus.imem_rd), 64'd0);
      checkOutput("misBusy", 64'(bus.busy), 64'd0);
      @(negedge clk);
    end
    checkOutput("misErr", 64'(bus.fetch_err), 64'd1);
    checkOutput("misInstr", 64'(bus.instr), 64'h0000_0013);

    // Flush lands in the same cycle as imem_ready: the data must be dropped.
    bus.pc        = 64'h48;
    bus.fetch_req = 1'b1;
    @(negedge clk);
    bus.fetch_req = 1'b0;
    checkOutput("flRdHigh", 64'(bus.imem_rd), 64'd1);
    bus.imem_ready = 1'b1;
    bus.imem_data  = 32'hFFFF_FFFF;
    bus.flush      = 1'b1;
    @(negedge clk);
    bus.imem_ready = 1'b0;
    bus.flush      = 1'b0;
    checkOutput("flValid", 64'(bus.instr_valid), 64'd0);
    checkOutput("flBusy", 64'(bus.busy), 64'd0);
    checkOutput("flRd", 64'(bus.imem_rd), 64'd0);
    checkOutput("flInstr", 64'(bus.instr), 64'h0000_0013);
    checkOutput("flErr", 64'(bus.fetch_err), 64'd0);
    @(negedge clk);
    checkOutput("flValidLate", 64'(bus.instr_valid), 64'd0);

    applyStimulus(64'h4C, 32'h0000_007F, 1, 4'd0, 1'b1);

    // Reset in the middle of a wait must drop the strobe without a clock edge.
    bus.pc        = 64'h50;
    bus.fetch_req = 1'b1;
    @(negedge clk);
    bus.fetch_req = 1'b0;
    checkOutput("rmRdHigh", 64'(bus.imem_rd), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("rmRdDrop", 64'(bus.imem_rd), 64'd0);
    checkOutput("rmInstr", 64'(bus.instr), 64'd0);
    checkOutput("rmAddr", bus.imem_addr, 64'd0);
    checkOutput("rmBusy", 64'(bus.busy), 64'd0);
    checkOutput("rmImmSel", 64'(bus.imm_sel), 64'd0);
    checkOutput("rmIllegal", 64'(bus.illegal), 64'd0);
    checkOutput("rmOpcode", 64'(bus.opcode), 64'd0);
    bus.imem_ready = 1'b1;
    bus.imem_data  = 32'h00A0_0093;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rmIgnValid", 64'(bus.instr_valid), 64'd0);
    checkOutput("rmIgnInstr", 64'(bus.instr), 64'd0);
    checkOutput("rmIgnRd", 64'(bus.imem_rd), 64'd0);
    bus.imem_ready = 1'b0;

    checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_reg.md
Name: instr_fetch_reg

Overview:
- Instruction fetch and instruction-register stage sitting directly upstream of the immediate extender.
- Issues a read to instruction memory on request from the control unit, tolerates variable memory latency, and latches the returned 32-bit word.
- Drives the extender's 32-bit input word and its 4-bit immediate-type select, decoded from the opcode.
- Also exports register/function fields and valid/error status to the control unit.

Parameters:
- TIMEOUT, 15, maximum number of cycles imem_rd stays asserted without imem_ready before the fetch is aborted (legal range 2..255).

Ports:
- clk  in  1  clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  start a fetch at pc; sampled only in IDLE.
- flush  in  1  abandon any fetch in progress.
- pc  in  64  fetch address.
- imem_addr  out  64  memory address, held for the whole request.
- imem_rd  out  1  memory read strobe.
- imem_ready  in  1  memory data valid this cycle.
- imem_data  in  32  memory read data.
- instr  out  32  instruction register; feeds the extender's 32-bit input.
- imm_sel  out  4  immediate type; feeds the extender's select.
- opcode  out  7  instr[6:0].
- rd  out  5  instr[11:7].
- rs1  out  5  instr[19:15].
- rs2  out  5  instr[24:20].
- funct3  out  3  instr[14:12].
- funct7  out  7  instr[31:25].
- instr_valid  out  1  one-cycle pulse when a new instruction is latched.
- illegal  out  1  latched opcode is not in the decode table.
- busy  out  1  state is not IDLE.
- fetch_err  out  1  sticky error: timeout or misaligned pc.

Behaviour:
- Reset (async, reset_n=0):
  - state IDLE; instr=0, imm_sel=0, imem_addr=0.
  - imem_rd, instr_valid, illegal, busy, fetch_err all 0; wait counter 0.
  - Field outputs are slices of instr, so they are 0.
- States: IDLE, WAIT.
- IDLE:
  - fetch_req=1, flush=0, pc[1:0]=0 → imem_addr<=pc, fetch_err<=0, counter<=0, go WAIT.
  - fetch_req=1, flush=0, pc[1:0]≠0 → fetch_err<=1, no memory access, stay IDLE, instr unchanged.
  - flush=1 overrides fetch_req: stay IDLE, no access.
- WAIT:
  - imem_rd=1 combinationally from state; imem_addr is stable.
  - On an edge with imem_ready=1 and flush=0: instr<=imem_data, imm_sel and illegal<=decode(imem_data[6:0]), instr_valid<=1 for exactly the next cycle, go IDLE.
  - On an edge with flush=1: go IDLE, discard data even if imem_ready=1, no instr_valid, fetch_err unchanged.
  - Otherwise: counter+1. If the counter was already TIMEOUT-1, set fetch_err<=1, go IDLE, leave instr unchanged.
  - imem_rd is therefore high for at most TIMEOUT cycles.
  - fetch_req is ignored while in WAIT.
- Latency: fetch_req sampled at edge N; imem_rd high in cycle N+1. If imem_ready is sampled at edge N+1, instr_valid is high in cycle N+2 with instr updated. A back-to-back fetch_req can be sampled at edge N+2.
- imem_ready is ignored in IDLE.
- instr and the decode outputs hold their value between fetches.
- fetch_err clears only on the next accepted aligned fetch, or on reset.
- Decode (imm_sel, illegal=0 unless stated):
  - 0000011, 0010011, 1100111, 1110011 → 0 (I-type).
  - 0100011 → 1 (S-type).
  - 1100011 → 2 (SB-type).
  - 0110111, 0010111 → 3 (U-type).
  - 1101111 → 4 (UJ-type).
  - 0110011 (R-type) → 0.
  - Any other opcode → 0 with illegal=1.
  - Value 5 is never produced here; it is reserved for the load-byte path.
- Reset asserted mid-WAIT: imem_rd drops asynchronously and all state returns to reset values.

Test Plan:
- Reset, then fetch_req with pc=0x40, imem_ready on first WAIT cycle, imem_data=0x00A00093 → imem_addr=0x40, imem_rd high exactly 1 cycle; instr=0x00A00093, imm_sel=0, rd=1, rs1=0, instr_valid for 1 cycle, latency 2 edges.
- Memory returns 0xFE112E23 after 3 wait cycles → imem_rd high 4 cycles, imm_sel=1, busy high throughout; then 0x0000006F → imm_sel=4; 0x000012B7 → imm_sel=3; 0xFE0008E3 → imm_sel=2.
- imem_ready never asserted, TIMEOUT=15 → imem_rd high exactly 15 cycles, fetch_err=1, instr keeps its previous value; next aligned fetch clears fetch_err.
- pc=0x42 with fetch_req → imem_rd never asserted, fetch_err=1, busy stays 0.
- flush in the same cycle as imem_ready with imem_data=0xFFFFFFFF → no instr_valid, instr unchanged, state IDLE; opcode 0x7F on a later fetch → illegal=1, imm_sel=0.
- reset_n pulled low mid-WAIT → imem_rd drops before the next clock edge; all outputs 0; a later imem_ready is ignored.
